pmem_arbiter: RTL and testbench
===============================

# pmem_arbiter

Parametrised N-port arbiter between the L1 cache controllers and the single physical-memory port. It generalises the one-cache-to-pmem link of the single-cache system to NUM_PORTS line-granular requesters (split I/D caches and later an L2 or DMA port). Grants are round-robin, and at most one transaction is outstanding. Each transaction is a full line read or write, carried to completion under the pmem handshake.

## Interface
Parameters:
- NUM_PORTS, 2: number of requesters; legal range is 2 to 8.
- LINE_WIDTH, 128: line width in bits, for both pmem data and requester data.
- ADDR_WIDTH, 16: byte address width.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_read  in  NUM_PORTS  per-port line read request; held until that port's req_resp.
- req_write  in  NUM_PORTS  per-port line write request; held until that port's req_resp.
- req_address  in  NUM_PORTS x ADDR_WIDTH  per-port line address.
- req_wdata  in  NUM_PORTS x LINE_WIDTH  per-port write line.
- req_resp  out  NUM_PORTS  one-hot, one-cycle completion pulse.
- req_rdata  out  LINE_WIDTH  read line, broadcast to all ports; valid only with req_resp.
- pmem_resp  in  1  physical memory completion.
- pmem_rdata  in  LINE_WIDTH  physical memory read line.
- pmem_read  out  1  physical memory read strobe.
- pmem_write  out  1  physical memory write strobe.
- pmem_address  out  ADDR_WIDTH  physical memory address.
- pmem_wdata  out  LINE_WIDTH  physical memory write line.

## Operation
- States: IDLE and BUSY, plus RESP when PMEM_ARB_RESP_REG_EN is defined.
- A port is pending when req_read[i] or req_write[i] is high.
- IDLE with no port pending: remain in IDLE.
- IDLE with at least one port pending:
  - Grant the first pending port found scanning upward from last_grant+1, wrapping modulo NUM_PORTS.
  - Latch the grant index, the op, address and wdata.
  - Go to BUSY.
- Op rule: if a port asserts both read and write, the write is serviced.
- BUSY:
  - pmem_read or pmem_write is driven from the latched op, with the latched address and wdata.
  - On pmem_resp: pulse req_resp[grant], set last_grant to grant, return to IDLE.
- Requests are latched at grant. A requester that drops its request while in BUSY does not abort the transaction; its req_resp still pulses.
- pmem_resp while in IDLE is ignored.
- After reset, last_grant is NUM_PORTS-1, so port 0 wins the first contested grant.

## Timing
- Reset values:
  - State IDLE.
  - pmem_read, pmem_write = 0.
  - pmem_address, pmem_wdata = 0.
  - req_resp = 0, req_rdata = 0.
  - Latched grant = 0, last_grant = NUM_PORTS-1.
- Reset asserted mid-transaction clears the strobes immediately (asynchronously). The pmem transaction is abandoned and no req_resp is issued.
- Request visible at edge k: pmem strobe is high from cycle k+1.
- Completion with pmem_resp in cycle m:
  - Without PMEM_ARB_RESP_REG_EN: req_resp and req_rdata (= pmem_rdata) are combinational in cycle m.
  - With it: they are registered and appear in cycle m+1.
- pmem strobes drop in the cycle after pmem_resp. At least one IDLE cycle separates transactions, giving requesters a cycle to deassert.
- Strobes, address and wdata are stable throughout BUSY.

## Configuration
- PMEM_ARB_RESP_REG_EN.
- Defined:
  - RESP state is added.
  - pmem_rdata is captured on pmem_resp.
  - req_resp[grant] and req_rdata are driven from registers one cycle later, then the FSM returns to IDLE.
  - Cuts the pmem-to-cache combinational path at a cost of one cycle.
- Undefined: req_resp and req_rdata are combinational pass-through of pmem_resp and pmem_rdata.

## Structure
- Shared package lc3b_types gains:
  - lc3b_mem_line: a LINE_WIDTH logic vector.
  - pmem_arb_state_t: an enum with IDLE, BUSY and RESP.
- Grant-index width is $clog2(NUM_PORTS), derived locally.
- Sub-module rr_arbiter: purely combinational. Inputs are the NUM_PORTS pending mask and last_grant. Outputs are grant_valid and grant_idx. It is instantiated once.

## Test plan
- Single read: port 0 reads 0x1230. pmem_read goes high the next cycle at 0x1230. pmem_resp with 0xDEAD...BEEF gives req_resp=2'b01 and req_rdata=0xDEAD...BEEF, in the same cycle (macro off) or one cycle later (macro on).
- Contention: ports 0 and 1 both read from reset. Port 0 is served first, then port 1. Then both again: order is 0 then 1 again, because last_grant was 1.
- Write: port 1 writes line 0xA5...A5 to 0x4000. pmem_write is high and pmem_wdata is stable for 3 cycles of pmem_resp delay. req_resp=2'b10 and pmem_read is never asserted.
- Simultaneous read and write on port 0: a single pmem_write is issued and no read.
- Reset asserted mid-BUSY: pmem_read falls without waiting for a clock edge, req_resp stays 0, and the next grant goes to port 0.
- Spurious pmem_resp in IDLE: no req_resp pulse and no state change. With NUM_PORTS=4, ports 1 and 3 pending after last_grant=3 are served in order 1 then 3.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types: cache line type and pmem arbiter states.
package lc3b_types;

  localparam int LC3B_LINE_WIDTH = 128;

  typedef logic [LC3B_LINE_WIDTH-1:0] lc3b_mem_line;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_arb_state_t;

endpackage

// File: rtl/pmem_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first pending port
// above last_grant, wrapping modulo NUM_PORTS.
module rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] pending,
  input  logic [IDX_W-1:0]     last_grant,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx
);

  // Scan upward from last_grant+1; the first hit wins, so last_grant itself is checked last.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(last_grant) + k) % NUM_PORTS;
      if (!grant_valid && pending[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: round-robin arbiter between NUM_PORTS line requesters and the
// single physical-memory port, one transaction outstanding at a time.
// Build option PMEM_ARB_RESP_REG_EN registers req_resp/req_rdata (adds RESP).
//
// state | meaning
// IDLE  | no transaction; grant the next pending port round-robin
// BUSY  | pmem strobe driven from latched op/address/wdata until pmem_resp
// RESP  | (PMEM_ARB_RESP_REG_EN only) registered req_resp/req_rdata pulse
module pmem_arbiter
  import lc3b_types::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req_read,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]            req_resp,
  output logic [LINE_WIDTH-1:0]           req_rdata,
  input  logic                            pmem_resp,
  input  logic [LINE_WIDTH-1:0]           pmem_rdata,
  output logic                            pmem_read,
  output logic                            pmem_write,
  output logic [ADDR_WIDTH-1:0]           pmem_address,
  output logic [LINE_WIDTH-1:0]           pmem_wdata
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [IDX_W-1:0] LAST_GRANT_RST = IDX_W'(NUM_PORTS - 1);

  pmem_arb_state_t        state, state_next;
  logic [NUM_PORTS-1:0]   pending;
  logic                   arb_valid;
  logic [IDX_W-1:0]       arb_idx;
  logic [IDX_W-1:0]       grant;
  logic [IDX_W-1:0]       last_grant;
  logic                   op_write;
  logic                   done;
  logic [NUM_PORTS-1:0]   grant_onehot;

  assign pending      = req_read | req_write;
  assign done         = (state == BUSY) && pmem_resp;
  assign grant_onehot = NUM_PORTS'(1) << grant;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr (
    .pending     (pending),
    .last_grant  (last_grant),
    .grant_valid (arb_valid),
    .grant_idx   (arb_idx)
  );

  // State register; async reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: grant from IDLE, finish on pmem_resp (via RESP when registered).
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (arb_valid) state_next = BUSY;
      BUSY: begin
        if (pmem_resp) begin
`ifdef PMEM_ARB_RESP_REG_EN
          state_next = RESP;
`else
          state_next = IDLE;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch the granted request so the pmem side stays stable even if the requester drops it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant        <= '0;
      last_grant   <= LAST_GRANT_RST;
      op_write     <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      if (state == IDLE && arb_valid) begin
        grant        <= arb_idx;
        op_write     <= req_write[arb_idx];
        pmem_address <= req_address[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        pmem_wdata   <= req_wdata[int'(arb_idx)*LINE_WIDTH +: LINE_WIDTH];
      end
      if (done) last_grant <= grant;
    end
  end

  // Strobes decode from state so reset drops them without waiting for an edge.
  assign pmem_read  = (state == BUSY) && !op_write;
  assign pmem_write = (state == BUSY) && op_write;

`ifdef PMEM_ARB_RESP_REG_EN
  logic [LINE_WIDTH-1:0] rdata_q;

  // Capture the read line on completion; it is replayed to the requesters from RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (done) rdata_q <= pmem_rdata;
  end

  assign req_resp  = (state == RESP) ? grant_onehot : '0;
  assign req_rdata = (state == RESP) ? rdata_q : '0;
`else
  assign req_resp  = done ? grant_onehot : '0;
  assign req_rdata = done ? pmem_rdata : '0;
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: a 2-port instance for the main scenarios
// and a 4-port instance for wrap-around ordering and spurious pmem_resp.
module tb_pmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]   a_req_read, a_req_write, a_req_resp;
  logic [31:0]  a_req_address;
  logic [255:0] a_req_wdata;
  logic [127:0] a_req_rdata, a_pmem_rdata, a_pmem_wdata;
  logic         a_pmem_resp, a_pmem_read, a_pmem_write;
  logic [15:0]  a_pmem_address;

  logic [3:0]   b_req_read, b_req_write, b_req_resp;
  logic [63:0]  b_req_address;
  logic [511:0] b_req_wdata;
  logic [127:0] b_req_rdata, b_pmem_rdata, b_pmem_wdata;
  logic         b_pmem_resp, b_pmem_read, b_pmem_write;
  logic [15:0]  b_pmem_address;

  pmem_arbiter #(.NUM_PORTS(2), .LINE_WIDTH(128), .ADDR_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst),
    .req_read(a_req_read), .req_write(a_req_write),
    .req_address(a_req_address), .req_wdata(a_req_wdata),
    .req_resp(a_req_resp), .req_rdata(a_req_rdata),
    .pmem_resp(a_pmem_resp), .pmem_rdata(a_pmem_rdata),
    .pmem_read(a_pmem_read), .pmem_write(a_pmem_write),
    .pmem_address(a_pmem_address), .pmem_wdata(a_pmem_wdata)
  );

  pmem_arbiter #(.NUM_PORTS(4), .LINE_WIDTH(128), .ADDR_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst),
    .req_read(b_req_read), .req_write(b_req_write),
    .req_address(b_req_address), .req_wdata(b_req_wdata),
    .req_resp(b_req_resp), .req_rdata(b_req_rdata),
    .pmem_resp(b_pmem_resp), .pmem_rdata(b_pmem_rdata),
    .pmem_read(b_pmem_read), .pmem_write(b_pmem_write),
    .pmem_address(b_pmem_address), .pmem_wdata(b_pmem_wdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Called in the first BUSY cycle; holds pmem_resp off for 'delay' cycles, then completes.
  task automatic serve_a(input string tag, input int port, input logic wr,
                         input logic [15:0] addr, input logic [127:0] wdata,
                         input logic [127:0] rdata, input int delay);
    logic [1:0] onehot;
    onehot = 2'b01 << port;
    for (int d = 0; d < delay; d++) begin
      check({tag, " rd strobe"}, 128'(a_pmem_read), 128'(!wr));
      check({tag, " wr strobe"}, 128'(a_pmem_write), 128'(wr));
      check({tag, " addr"}, 128'(a_pmem_address), 128'(addr));
      if (wr) check({tag, " wdata"}, a_pmem_wdata, wdata);
      check({tag, " early resp"}, 128'(a_req_resp), 128'(0));
      tick();
    end
    a_pmem_resp  = 1'b1;
    a_pmem_rdata = rdata;
    #1;
    check({tag, " rd strobe@resp"}, 128'(a_pmem_read), 128'(!wr));
    check({tag, " wr strobe@resp"}, 128'(a_pmem_write), 128'(wr));
`ifndef PMEM_ARB_RESP_REG_EN
    check({tag, " req_resp"}, 128'(a_req_resp), 128'(onehot));
    if (!wr) check({tag, " req_rdata"}, a_req_rdata, rdata);
`endif
    a_req_read[port]  = 1'b0;
    a_req_write[port] = 1'b0;
    tick();
    a_pmem_resp  = 1'b0;
    a_pmem_rdata = '0;
    check({tag, " rd drop"}, 128'(a_pmem_read), 128'(0));
    check({tag, " wr drop"}, 128'(a_pmem_write), 128'(0));
`ifdef PMEM_ARB_RESP_REG_EN
    check({tag, " req_resp"}, 128'(a_req_resp), 128'(onehot));
    if (!wr) check({tag, " req_rdata"}, a_req_rdata, rdata);
    tick();
`endif
    check({tag, " resp cleared"}, 128'(a_req_resp), 128'(0));
  endtask

  task automatic serve_b(input string tag, input int port,
                         input logic [15:0] addr, input logic [127:0] rdata);
    logic [3:0] onehot;
    onehot = 4'b0001 << port;
    check({tag, " rd strobe"}, 128'(b_pmem_read), 128'(1));
    check({tag, " addr"}, 128'(b_pmem_address), 128'(addr));
    b_pmem_resp  = 1'b1;
    b_pmem_rdata = rdata;
    #1;
`ifndef PMEM_ARB_RESP_REG_EN
    check({tag, " req_resp"}, 128'(b_req_resp), 128'(onehot));
    check({tag, " req_rdata"}, b_req_rdata, rdata);
`endif
    b_req_read[port] = 1'b0;
    tick();
    b_pmem_resp  = 1'b0;
    b_pmem_rdata = '0;
    check({tag, " rd drop"}, 128'(b_pmem_read), 128'(0));
`ifdef PMEM_ARB_RESP_REG_EN
    check({tag, " req_resp"}, 128'(b_req_resp), 128'(onehot));
    check({tag, " req_rdata"}, b_req_rdata, rdata);
    tick();
`endif
  endtask

  localparam logic [127:0] LINE_DB = 128'hDEAD0000_00000000_00000000_0000BEEF;
  localparam logic [127:0] LINE_A5 = {16{8'hA5}};
  localparam logic [127:0] LINE_W0 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

  initial begin
    a_req_read = '0; a_req_write = '0; a_req_address = '0; a_req_wdata = '0;
    a_pmem_resp = 1'b0; a_pmem_rdata = '0;
    b_req_read = '0; b_req_write = '0; b_req_address = '0; b_req_wdata = '0;
    b_pmem_resp = 1'b0; b_pmem_rdata = '0;

    #1;
    check("rst pmem_read", 128'(a_pmem_read), 128'(0));
    check("rst pmem_write", 128'(a_pmem_write), 128'(0));
    check("rst pmem_address", 128'(a_pmem_address), 128'(0));
    check("rst pmem_wdata", a_pmem_wdata, 128'(0));
    check("rst req_resp", 128'(a_req_resp), 128'(0));
    check("rst req_rdata", a_req_rdata, 128'(0));
    tick();
    rst = 1'b0;
    tick();
    check("idle no strobe", 128'(a_pmem_read | a_pmem_write), 128'(0));

    // Single read from port 0.
    a_req_address[15:0] = 16'h1230;
    a_req_read[0] = 1'b1;
    tick();
    serve_a("single_rd", 0, 1'b0, 16'h1230, '0, LINE_DB, 1);

    // Contention from reset: 0 then 1, and again 0 then 1.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      a_req_address = {16'h2000, 16'h1000};
      a_req_read = 2'b11;
      tick();
      serve_a("cont p0", 0, 1'b0, 16'h1000, '0, 128'(32'h1000 + r), 1);
      tick();
      serve_a("cont p1", 1, 1'b0, 16'h2000, '0, 128'(32'h2000 + r), 2);
    end

    // Port 1 line write with a 3-cycle pmem delay.
    tick();
    a_req_address[31:16] = 16'h4000;
    a_req_wdata[255:128] = LINE_A5;
    a_req_write[1] = 1'b1;
    tick();
    serve_a("write p1", 1, 1'b1, 16'h4000, LINE_A5, '0, 3);

    // Read and write together on port 0: write wins.
    tick();
    a_req_address[15:0] = 16'h5550;
    a_req_wdata[127:0]  = LINE_W0;
    a_req_read[0] = 1'b1;
    a_req_write[0] = 1'b1;
    tick();
    serve_a("rdwr p0", 0, 1'b1, 16'h5550, LINE_W0, '0, 2);

    // Requester drops its request mid-BUSY; transaction still completes.
    tick();
    a_req_address[15:0] = 16'h0440;
    a_req_read[0] = 1'b1;
    tick();
    a_req_read[0] = 1'b0;
    serve_a("drop p0", 0, 1'b0, 16'h0440, '0, 128'h55, 2);

    // Reset mid-BUSY on port 1; next grant goes to port 0.
    tick();
    a_req_address = {16'h6000, 16'h7000};
    a_req_read[1] = 1'b1;
    tick();
    check("pre-rst rd strobe", 128'(a_pmem_read), 128'(1));
    a_req_read[0] = 1'b1;
    rst = 1'b1;
    #1;
    check("async rst rd strobe", 128'(a_pmem_read), 128'(0));
    check("async rst req_resp", 128'(a_req_resp), 128'(0));
    tick();
    rst = 1'b0;
    tick();
    serve_a("post-rst p0", 0, 1'b0, 16'h7000, '0, 128'h70, 1);
    tick();
    serve_a("post-rst p1", 1, 1'b0, 16'h6000, '0, 128'h60, 1);

    // 4-port instance: spurious pmem_resp in IDLE, then ports 1 and 3 in order.
    do_reset();
    b_pmem_resp = 1'b1;
    b_pmem_rdata = 128'hBAD;
    #1;
    check("spur req_resp", 128'(b_req_resp), 128'(0));
    tick();
    check("spur no strobe", 128'(b_pmem_read | b_pmem_write), 128'(0));
    check("spur req_resp2", 128'(b_req_resp), 128'(0));
    b_pmem_resp = 1'b0;
    b_pmem_rdata = '0;
    tick();
    check("spur still idle", 128'(b_pmem_read | b_pmem_write), 128'(0));
    b_req_address[31:16] = 16'h1111;
    b_req_address[63:48] = 16'h3333;
    b_req_read = 4'b1010;
    tick();
    serve_b("b p1", 1, 16'h1111, 128'h11);
    tick();
    serve_b("b p3", 3, 16'h3333, 128'h33);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
